// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every N_IN-bit input vector in binary order,
// holds each one for HOLD cycles, samples the DUT response on the last hold
// cycle and compares it against the EXPECT table. It reports pass/fail, a
// saturating mismatch count and the first failing vector.
module truth_table_sweeper #(
    parameter int                   N_IN   = 3,
    parameter int                   HOLD   = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 8'b1110_1000,
    parameter int                   ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              dut_out,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    // hold_cnt only ever reaches HOLD-1; keep at least one bit so HOLD=1 is legal
    localparam int              HC_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [HC_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [N_IN-1:0]   stim_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              pass_nxt;
    logic [ERR_W-1:0]  err_cnt_nxt;
    logic [N_IN-1:0]   first_err_vec_nxt;
    logic              first_err_valid_nxt;

    logic              sample;
    logic              mismatch;

    assign sample   = (hold_cnt == HOLD_LAST);
    assign mismatch = (dut_out != EXPECT[stim]);

    // State and output registers; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            hold_cnt        <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            state           <= state_nxt;
            hold_cnt        <= hold_cnt_nxt;
            stim            <= stim_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            pass            <= pass_nxt;
            err_cnt         <= err_cnt_nxt;
            first_err_vec   <= first_err_vec_nxt;
            first_err_valid <= first_err_valid_nxt;
        end
    end

    // Next-state and next-output logic; abort takes priority over start
    always_comb begin
        state_nxt           = state;
        hold_cnt_nxt        = hold_cnt;
        stim_nxt            = stim;
        busy_nxt            = busy;
        done_nxt            = done;
        pass_nxt            = pass;
        err_cnt_nxt         = err_cnt;
        first_err_vec_nxt   = first_err_vec;
        first_err_valid_nxt = first_err_valid;

        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                end else if (start) begin
                    state_nxt           = RUN;
                    stim_nxt            = '0;
                    hold_cnt_nxt        = '0;
                    busy_nxt            = 1'b1;
                    done_nxt            = 1'b0;
                    pass_nxt            = 1'b0;
                    err_cnt_nxt         = '0;
                    first_err_vec_nxt   = '0;
                    first_err_valid_nxt = 1'b0;
                end
            end

            RUN: begin
                if (abort) begin
                    // partial error results are deliberately kept
                    state_nxt    = IDLE;
                    stim_nxt     = '0;
                    hold_cnt_nxt = '0;
                    busy_nxt     = 1'b0;
                    done_nxt     = 1'b0;
                    pass_nxt     = 1'b0;
                end else if (!sample) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end else begin
                    if (mismatch) begin
                        if (err_cnt != '1) begin
                            err_cnt_nxt = err_cnt + 1'b1;
                        end
                        if (!first_err_valid) begin
                            first_err_vec_nxt   = stim;
                            first_err_valid_nxt = 1'b1;
                        end
                    end
                    hold_cnt_nxt = '0;
                    if (stim == STIM_LAST) begin
                        // pass reflects the count including this final sample
                        state_nxt = DONE;
                        stim_nxt  = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_cnt_nxt == '0);
                    end else begin
                        stim_nxt = stim + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: majority, stuck-at-0 and inverted
// DUT models, start re-pulses, mid-sweep reset and abort.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    int         mode;          // 0: majority, 1: stuck-at-0

    // main instance, defaults (N_IN=3, HOLD=2, ERR_W=8)
    logic       dut_out;
    logic [2:0] stim;
    logic       busy, done, pass, first_err_valid;
    logic [7:0] err_cnt;
    logic [2:0] first_err_vec;

    // ERR_W=2 instance driven by an inverted majority
    logic       e2_dut_out;
    logic [2:0] e2_stim;
    logic       e2_busy, e2_done, e2_pass, e2_first_err_valid;
    logic [1:0] e2_err_cnt;
    logic [2:0] e2_first_err_vec;

    // HOLD=1 instance driven by a correct majority
    logic       h1_dut_out;
    logic [2:0] h1_stim;
    logic       h1_busy, h1_done, h1_pass, h1_first_err_valid;
    logic [7:0] h1_err_cnt;
    logic [2:0] h1_first_err_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    assign dut_out    = (mode == 1) ? 1'b0 : maj(stim);
    assign e2_dut_out = ~maj(e2_stim);
    assign h1_dut_out = maj(h1_stim);

    truth_table_sweeper u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dut_out),
        .stim(stim), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
    );

    truth_table_sweeper #(.ERR_W(2)) u_e2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(e2_dut_out),
        .stim(e2_stim), .busy(e2_busy), .done(e2_done), .pass(e2_pass),
        .err_cnt(e2_err_cnt), .first_err_vec(e2_first_err_vec),
        .first_err_valid(e2_first_err_valid)
    );

    truth_table_sweeper #(.HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(h1_dut_out),
        .stim(h1_stim), .busy(h1_busy), .done(h1_done), .pass(h1_pass),
        .err_cnt(h1_err_cnt), .first_err_vec(h1_first_err_vec),
        .first_err_valid(h1_first_err_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // start is seen by the next rising edge; returns at the negedge after it
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_stim",  stim, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_pass",  pass, 0);
        check("rst_err",   err_cnt, 0);
        check("rst_fev",   first_err_vec, 0);
        check("rst_fval",  first_err_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // correct majority: 16 busy cycles, stim 0..7 each held 2 cycles
        mode = 0;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            check("sweep_busy", busy, 1);
            check("sweep_stim", stim, i / 2);
            if (i == 7) check("h1_busy_last", h1_busy, 1);
            if (i == 8) begin
                check("h1_busy_end", h1_busy, 0);
                check("h1_done", h1_done, 1);
                check("h1_pass", h1_pass, 1);
            end
            @(negedge clk);
        end
        check("ok_busy", busy, 0);
        check("ok_done", done, 1);
        check("ok_pass", pass, 1);
        check("ok_err",  err_cnt, 0);
        check("ok_fval", first_err_valid, 0);
        check("ok_stim", stim, 0);
        // inverted majority on ERR_W=2: 8 mismatches saturate at 3
        check("e2_done", e2_done, 1);
        check("e2_err",  e2_err_cnt, 3);
        check("e2_fev",  e2_first_err_vec, 0);
        check("e2_fval", e2_first_err_valid, 1);
        check("e2_pass", e2_pass, 0);
        repeat (3) @(negedge clk);
        check("done_hold", done, 1);

        // stuck-at-0: mismatches at 3,5,6,7
        mode = 1;
        pulse_start();
        repeat (16) @(negedge clk);
        check("s0_done", done, 1);
        check("s0_err",  err_cnt, 4);
        check("s0_fev",  first_err_vec, 3);
        check("s0_fval", first_err_valid, 1);
        check("s0_pass", pass, 0);

        // start re-pulsed mid-sweep is ignored
        mode = 0;
        pulse_start();
        check("rs_clear_err",  err_cnt, 0);
        check("rs_clear_fval", first_err_valid, 0);
        check("rs_clear_done", done, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 9) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check("rs_busy", busy, 0);
        check("rs_done", done, 1);
        check("rs_pass", pass, 1);
        // start in DONE begins a fresh sweep
        pulse_start();
        check("rd_done", done, 0);
        check("rd_busy", busy, 1);
        repeat (16) @(negedge clk);
        check("rd_done2", done, 1);
        check("rd_pass2", pass, 1);

        // reset mid-sweep
        mode = 1;
        pulse_start();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_stim", stim, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_err",  err_cnt, 0);
        check("mr_fval", first_err_valid, 0);
        repeat (5) @(negedge clk);
        check("mr_idle_busy", busy, 0);
        check("mr_idle_stim", stim, 0);

        // abort after vector 3 was sampled with stuck-at-0 DUT
        mode = 1;
        pulse_start();
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_stim", stim, 0);
        check("ab_err",  err_cnt, 1);
        check("ab_fev",  first_err_vec, 3);
        check("ab_fval", first_err_valid, 1);
        repeat (3) @(negedge clk);
        check("ab_idle", busy, 0);

        // abort with start in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("ab_start_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking stimulus sequencer for small combinational lab DUTs. Generalises the fixed 3-input (A, B, C) bench to N inputs.
- Walks all 2^N input vectors in binary order and holds each for HOLD cycles.
- Samples the DUT's single output on the last hold cycle and compares it against a parameterised expected truth table.
- Reports pass/fail, a saturating mismatch count and the first failing vector. Used both as a simulation bench core and as an on-board self-test.

Parameters:
- N_IN, 3, number of DUT inputs (1..8).
- HOLD, 2, cycles each vector is driven before sampling (>=1).
- EXPECT, 8'b1110_1000, expected truth table. Width 2^N_IN. Bit v is the expected output for input vector v; the default is 3-input majority.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- abort  in  1  synchronous abort; returns to IDLE without asserting done.
- dut_out  in  1  DUT response to stim.
- stim  out  N_IN  vector driven to DUT inputs (stim[N_IN-1] = MSB = A).
- busy  out  1  high while a sweep is running.
- done  out  1  high (level) from sweep completion until the next start or rst.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  out  ERR_W  mismatch count, saturating.
- first_err_vec  out  N_IN  first vector that mismatched.
- first_err_valid  out  1  first_err_vec holds a captured value.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: stim=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0, state=IDLE, hold_cnt=0.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at an edge:
  - Next state RUN; stim=0, hold_cnt=0, busy=1.
  - done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0.
- RUN, each edge with hold_cnt<HOLD-1: hold_cnt++, stim unchanged.
- RUN, edge with hold_cnt==HOLD-1 (sample edge):
  - Compare dut_out with EXPECT[stim].
  - On mismatch: err_cnt++ unless it is all-ones (saturates). If first_err_valid=0, set first_err_vec=stim and first_err_valid=1.
  - Then hold_cnt=0. If stim==2^N_IN-1: go to DONE, stim=0, busy=0, done=1, pass=(final err_cnt==0, including this sample). Otherwise stim++.
- Sweep length: busy is high for exactly 2^N_IN*HOLD cycles. done rises on the same edge busy falls.
- start while RUN: ignored.
- Simultaneous abort and start in RUN: abort wins.
- abort in RUN:
  - Next state IDLE; stim=0, busy=0, done=0, pass=0.
  - err_cnt, first_err_vec and first_err_valid keep their partial values.
- abort in IDLE or DONE: IDLE; done=0, pass=0.
- DONE: outputs hold until start, abort or rst.
- rst has priority over everything, in any state including mid-sweep: all registers return to reset values on that edge.
- HOLD=1: every RUN edge is a sample edge.
- DUT output must settle within HOLD-1 cycles plus the combinational path; the block adds no extra sampling latency.

Test Plan:
- N_IN=3, HOLD=2, DUT = correct majority; pulse start at cycle 0 -> busy high for 16 cycles; stim sequence 0..7, each held 2 cycles; done=1, pass=1, err_cnt=0, first_err_valid=0.
- Same setup, DUT stuck-at-0 -> err_cnt=4, first_err_vec=3'b011, first_err_valid=1, pass=0.
- DUT = inverted majority, ERR_W=2 -> mismatches on all 8 vectors; err_cnt saturates at 3; first_err_vec=0; pass=0.
- Correct DUT; start re-pulsed at cycles 3 and 9 -> ignored, sweep ends at cycle 16; then start again in DONE -> done drops next cycle, counters cleared, a new 16-cycle sweep completes with pass=1.
- rst asserted at cycle 5 of a sweep -> next edge stim=0, busy=0, done=0, err_cnt=0, and the block stays in IDLE.
- abort at cycle 7 with stuck-at-0 DUT (one mismatch so far at vector 3) -> IDLE, busy=0, done=0, err_cnt=1, first_err_vec=3 retained.
